// File: rtl/vga_frame_reader.sv
// vga_frame_reader: display-side reader of the data RAM's VGA port.
// Generates 640x480@60 timing from the pixel enable 'tick'. Fetches a
// 160x120 framebuffer (4 bits per pixel, 8 pixels per 32-bit word).
// Each logical pixel is shown as a 4x4 block of 12-bit palette colour.
// Emits a one-clk vblank_start pulse for frame pacing.
// Optional feature macro: VGA_PALETTE_WR_EN. When it is defined, the
// palette is a writable 16x12 register file loaded with the fixed table on
// rst. When it is undefined, the palette is a constant table.
module vga_frame_reader #(
  parameter logic [11:0] FB_BASE        = 12'h600,
  parameter int          WORDS_PER_LINE = 20,
  parameter int          H_ACTIVE       = 640,
  parameter int          H_FP           = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BP           = 48,
  parameter int          V_ACTIVE       = 480,
  parameter int          V_FP           = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BP           = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  output logic [11:0] vgaaddr,
  input  logic [31:0] vgavalue,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank_start
`ifdef VGA_PALETTE_WR_EN
  ,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data
`endif
);

  // Counters are 10 bits wide, which covers totals up to 1024 per axis.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Fixed 16-entry palette, 4:4:4 RGB.
  function automatic logic [11:0] pal_rom(input logic [3:0] idx);
    logic [11:0] c;
    case (idx)
      4'h0: c = 12'h000;
      4'h1: c = 12'hFFF;
      4'h2: c = 12'hF00;
      4'h3: c = 12'h0F0;
      4'h4: c = 12'h00F;
      4'h5: c = 12'hFF0;
      4'h6: c = 12'h0FF;
      4'h7: c = 12'hF0F;
      4'h8: c = 12'h888;
      4'h9: c = 12'h444;
      4'hA: c = 12'h4C4;
      4'hB: c = 12'h8CF;
      4'hC: c = 12'hF80;
      4'hD: c = 12'h840;
      4'hE: c = 12'hEDA;
      default: c = 12'h222;
    endcase
    return c;
  endfunction

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        active;
  logic [11:0] row_off;
  logic [11:0] col_off;
  logic [2:0]  nib;
  logic [3:0]  pix_idx;
  logic [11:0] pal_color;
  logic        hs_next;
  logic        vs_next;
  logic        frame_end_tick;
  logic [11:0] rgb;

`ifdef VGA_PALETTE_WR_EN
  logic [11:0] pal_q [16];

  // Writable palette: rst reloads the fixed table; writes ignore tick.
  // NOTE: a 16-entry register file (not a RAM macro) can take a reset, and
  // rst must restore the fixed colours, so every entry is reset here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= pal_rom(4'(i));
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end
`endif

  // Pixel and line counters; they move only on pixel-enable cycles.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of the others, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Address, pixel select, palette lookup and sync decode from the counters.
  // NOTE: every signal gets a value at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    active         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    row_off        = 12'(32'(v_cnt[9:2]) * WORDS_PER_LINE);
    col_off        = 12'(h_cnt[9:5]);
    vgaaddr        = FB_BASE;
    nib            = h_cnt[4:2];
    pix_idx        = vgavalue[{nib, 2'b00} +: 4];
    hs_next        = ~((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_next        = ~((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    frame_end_tick = tick && (h_cnt == H_LAST) && (v_cnt == V_ACT_LAST);
`ifdef VGA_PALETTE_WR_EN
    pal_color      = pal_q[pix_idx];
`else
    pal_color      = pal_rom(pix_idx);
`endif
    if (active) begin
      vgaaddr = FB_BASE + row_off + col_off;
    end
  end

  // Output stage: colour and syncs registered on tick, one tick behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb    <= 12'h000;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else if (tick) begin
      rgb    <= active ? pal_color : 12'h000;
      vga_hs <= hs_next;
      vga_vs <= vs_next;
    end
  end

  // One-clk vblank pulse on the clk after the last active pixel's tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblank_start <= 1'b0;
    end else begin
      vblank_start <= frame_end_tick;
    end
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader.
// Instance 'dut' runs full 640x480 timing for line-level checks at 1-in-4 ticks.
// Instance 'dut_s' keeps the vertical timing but uses a 40-pixel line, so a
// whole frame (vblank, vsync, vertical blanking, bottom-row address) fits a
// short run.
module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_b = 1'b0;
  logic        tick_s = 1'b0;
  logic [31:0] val_b = '0;
  logic [31:0] val_s = '0;
  logic [11:0] addr_b, addr_s;
  logic [3:0]  r_b, g_b, b_b, r_s, g_s, b_s;
  logic        hs_b, vs_b, vb_b, hs_s, vs_s, vb_s;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [11:0] pal_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_frame_reader dut (
    .clk(clk), .rst(rst), .tick(tick_b), .vgaaddr(addr_b), .vgavalue(val_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
    .vblank_start(vb_b)
`ifdef VGA_PALETTE_WR_EN
    , .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data)
`endif
  );

  vga_frame_reader #(.H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_s (
    .clk(clk), .rst(rst), .tick(tick_s), .vgaaddr(addr_s), .vgavalue(val_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s),
    .vblank_start(vb_s)
`ifdef VGA_PALETTE_WR_EN
    , .pal_we(1'b0), .pal_idx(4'h0), .pal_data(12'h000)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // n ticks on the full-size instance, one tick every 4 clk.
  task automatic tick_big(input int n);
    for (int i = 0; i < n; i++) begin
      tick_b = 1'b1;
      @(posedge clk); #1;
      tick_b = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end
  endtask

  // n back-to-back ticks on the small instance.
  task automatic tick_small_fast(input int n);
    if (n > 0) begin
      tick_s = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      tick_s = 1'b0;
    end
  endtask

  typedef struct {
    int          adv;
    logic [31:0] val;
    logic [11:0] addr;
    logic [11:0] rgb;
    logic        hs;
  } vec_t;

  vec_t vecs [16];

  int hs_low, vs_low, hs_low_s, vb_cnt, vb_pos, rgb_nz, changes;

  initial begin
    // Row 0 of the full-size instance, starting from (0,0) after reset.
    vecs[0]  = '{4,   32'h76543210, 12'h600, 12'h000, 1'b1};
    vecs[1]  = '{4,   32'h76543210, 12'h600, 12'hFFF, 1'b1};
    vecs[2]  = '{4,   32'h76543210, 12'h600, 12'hF00, 1'b1};
    vecs[3]  = '{4,   32'h76543210, 12'h600, 12'h0F0, 1'b1};
    vecs[4]  = '{4,   32'h76543210, 12'h600, 12'h00F, 1'b1};
    vecs[5]  = '{4,   32'h76543210, 12'h600, 12'hFF0, 1'b1};
    vecs[6]  = '{4,   32'h76543210, 12'h600, 12'h0FF, 1'b1};
    vecs[7]  = '{4,   32'h76543210, 12'h601, 12'hF0F, 1'b1};  // now h=32
    vecs[8]  = '{608, 32'hFFFFFFFF, 12'h600, 12'h222, 1'b1};  // h=640, shows px 639
    vecs[9]  = '{1,   32'hFFFFFFFF, 12'h600, 12'h000, 1'b1};  // px 640 blank
    vecs[10] = '{15,  32'hFFFFFFFF, 12'h600, 12'h000, 1'b1};  // px 655
    vecs[11] = '{1,   32'hFFFFFFFF, 12'h600, 12'h000, 1'b0};  // px 656 sync
    vecs[12] = '{95,  32'hFFFFFFFF, 12'h600, 12'h000, 1'b0};  // px 751 sync
    vecs[13] = '{1,   32'hFFFFFFFF, 12'h600, 12'h000, 1'b1};  // px 752
    vecs[14] = '{46,  32'hFFFFFFFF, 12'h600, 12'h000, 1'b1};  // h=799
    vecs[15] = '{1,   32'hFFFFFFFF, 12'h600, 12'h000, 1'b1};  // (0,1)

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", addr_b, 12'h600);
    check("reset_rgb", {r_b, g_b, b_b}, 12'h000);
    check("reset_syncs", {hs_b, vs_b, vb_b}, 3'b110);
    rst = 1'b0;

    // Row 0: pixel pattern, horizontal blanking, hsync edges.
    for (int i = 0; i < 16; i++) begin
      val_b = vecs[i].val;
      tick_big(vecs[i].adv);
      check($sformatf("vec%0d_addr", i), addr_b, vecs[i].addr);
      check($sformatf("vec%0d_rgb", i), {r_b, g_b, b_b}, vecs[i].rgb);
      check($sformatf("vec%0d_hs", i), hs_b, vecs[i].hs);
    end

    // Line 1: hsync low count over one full line.
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      tick_big(1);
      if (!hs_b) hs_low++;
    end
    check("hs_low_per_line", hs_low, 96);

    // Move to (32,4).
    val_b = 32'h76543210;
    tick_big(1632);
    check("addr_32_4", addr_b, 12'h615);
    check("rgb_31_4", {r_b, g_b, b_b}, 12'hF0F);

    // tick held low for 100 clk: nothing may move.
    changes = 0;
    val_b = 32'hFFFFFFFF;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (addr_b !== 12'h615 || {r_b, g_b, b_b} !== 12'hF0F || hs_b !== 1'b1 || vs_b !== 1'b1)
        changes++;
    end
    check("tick_low_hold", changes, 0);

    // Reset mid-line at (300,4) together with a tick.
    tick_big(268);
    check("pre_rst_addr", addr_b, 12'h61D);
    check("pre_rst_rgb", {r_b, g_b, b_b}, 12'h222);
    rst = 1'b1;
    tick_b = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick_b = 1'b0;
    check("rst_addr", addr_b, 12'h600);
    check("rst_rgb", {r_b, g_b, b_b}, 12'h000);
    check("rst_syncs", {hs_b, vs_b, vb_b}, 3'b110);
    val_b = 32'h76543210;
    tick_big(32);
    check("restart_addr", addr_b, 12'h601);
    check("restart_rgb", {r_b, g_b, b_b}, 12'hF0F);

`ifdef VGA_PALETTE_WR_EN
    // Palette write, same-cycle write/read, reset reload. Position (32,0).
    val_b = 32'h11111111;
    pal_we = 1'b1; pal_idx = 4'h1; pal_data = 12'h0A5;
    @(posedge clk); #1;
    pal_we = 1'b0;
    tick_big(1);
    check("pal_write", {r_b, g_b, b_b}, 12'h0A5);
    pal_we = 1'b1; pal_data = 12'h123; tick_b = 1'b1;
    @(posedge clk); #1;
    pal_we = 1'b0; tick_b = 1'b0;
    check("pal_same_cycle_old", {r_b, g_b, b_b}, 12'h0A5);
    tick_big(1);
    check("pal_new_value", {r_b, g_b, b_b}, 12'h123);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick_big(1);
    check("pal_after_rst", {r_b, g_b, b_b}, 12'hFFF);
`endif

    // Small instance: reach (0,476), then walk the rest of the frame.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    val_s = 32'hFFFFFFFF;
    tick_small_fast(476 * 40);
    check("addr_0_476", addr_s, 12'hF4C);

    vs_low = 0; hs_low_s = 0; vb_cnt = 0; vb_pos = 0; rgb_nz = 0;
    for (int i = 1; i <= 49 * 40; i++) begin
      tick_s = 1'b1;
      @(posedge clk); #1;
      tick_s = 1'b0;
      if (!vs_s) vs_low++;
      if (!hs_s) hs_low_s++;
      if ({r_s, g_s, b_s} != 12'h000) rgb_nz++;
      if (vb_s) begin vb_cnt++; vb_pos = i; end
      @(posedge clk); #1;
      if (vb_s) vb_cnt++;
    end
    check("vblank_count", vb_cnt, 1);
    check("vblank_position", vb_pos, 160);
    check("vs_low_per_frame", vs_low, 80);
    check("hs_low_window", hs_low_s, 196);
    check("visible_px_in_window", rgb_nz, 128);
    check("frame_wrap_addr", addr_s, 12'h600);

    // Small instance: reset while hsync is low.
    tick_small_fast(36);
    check("pre_rst_hs_low", hs_s, 1'b0);
    rst = 1'b1;
    tick_s = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick_s = 1'b0;
    check("rst_small_syncs", {hs_s, vs_s, vb_s}, 3'b110);
    check("rst_small_rgb", {r_s, g_s, b_s}, 12'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
